// File: rtl/shiftreg_engine.sv
// shiftreg_engine: multi-lane serial shift engine with a shared control path.
// Each lane loads a parallel word, shifts it out over a programmable frame of
// 1..WIDTH strobed bits while capturing the serial input, and returns the
// captured bits low-justified with a one-cycle completion pulse.
module shiftreg_engine #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int DIRECTION = 0,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   abort,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*WIDTH-1:0] s_data,
    input  logic [CW-1:0]          len,
    input  logic [LANES-1:0]       shiftin,
    output logic [LANES-1:0]       shiftout,
    output logic                   busy,
    output logic                   m_valid,
    output logic [LANES*WIDTH-1:0] m_data
);

    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [LANES*WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          len_q, len_d;
    logic [LANES*WIDTH-1:0] mdata_q, mdata_d;
    logic                   mvalid_q, mvalid_d;

    // Frame length actually used: 0 and anything above WIDTH mean a full word.
    function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] l);
        logic [CW-1:0] r;
        if ((l == '0) || (l > WIDTH_C)) begin
            r = WIDTH_C;
        end else begin
            r = l;
        end
        return r;
    endfunction

    // One shift step of a single lane, inserting the serial input bit.
    function automatic logic [WIDTH-1:0] shift_lane(input logic [WIDTH-1:0] r,
                                                    input logic b);
        logic [WIDTH-1:0] s;
        if (DIRECTION == 0) begin
            s = {b, r[WIDTH-1:1]};
        end else begin
            s = {r[WIDTH-2:0], b};
        end
        return s;
    endfunction

    // Low-justify the n received bits of a lane; upper bits forced to zero.
    function automatic logic [WIDTH-1:0] align_lane(input logic [WIDTH-1:0] r,
                                                    input logic [CW-1:0] n);
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] a;
        mask = ~({WIDTH{1'b1}} << n);
        if (DIRECTION == 0) begin
            a = (r >> (WIDTH_C - n)) & mask;
        end else begin
            a = r & mask;
        end
        return a;
    endfunction

    // Next-state logic: abort wins, then load in IDLE, then strobed shifting.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        mdata_d  = mdata_q;
        mvalid_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
            len_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        sreg_d  = s_data;
                        cnt_d   = eff_len(len);
                        len_d   = eff_len(len);
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (en) begin
                        for (int k = 0; k < LANES; k++) begin
                            sreg_d[k*WIDTH +: WIDTH] =
                                shift_lane(sreg_q[k*WIDTH +: WIDTH], shiftin[k]);
                        end
                        cnt_d = cnt_q - ONE_C;
                        if (cnt_q == ONE_C) begin
                            state_d  = ST_IDLE;
                            mvalid_d = 1'b1;
                            for (int k = 0; k < LANES; k++) begin
                                mdata_d[k*WIDTH +: WIDTH] =
                                    align_lane(sreg_d[k*WIDTH +: WIDTH], len_q);
                            end
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                    len_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
        end
    end

    assign s_ready = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_SHIFT);
    assign m_valid = mvalid_q;
    assign m_data  = mdata_q;

    for (genvar k = 0; k < LANES; k++) begin : g_out
        if (DIRECTION == 0) begin : g_right
            assign shiftout[k] = sreg_q[k*WIDTH];
        end else begin : g_left
            assign shiftout[k] = sreg_q[k*WIDTH + WIDTH - 1];
        end
    end

endmodule

// File: tb/tb_shiftreg_engine.sv
// Bench for shiftreg_engine: a 2-lane right-shifting instance and a 1-lane
// left-shifting instance share one stimulus stream. A bit-queue model of
// each lane predicts every output on every cycle; directed frames add
// hand-computed literal expectations.
module tb_shiftreg_engine;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b1;
    logic        abort = 1'b0;
    logic        en = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic [3:0]  len = 4'd0;
    logic [1:0]  shiftin = 2'b00;

    logic        s_ready_a, busy_a, m_valid_a;
    logic [1:0]  shiftout_a;
    logic [15:0] m_data_a;
    logic        s_ready_b, busy_b, m_valid_b;
    logic [0:0]  shiftout_b;
    logic [7:0]  m_data_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    shiftreg_engine #(.WIDTH(8), .LANES(2), .DIRECTION(0)) dut_a (
        .clk(clk), .aclr_n(aclr_n), .abort(abort), .en(en),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data), .len(len),
        .shiftin(shiftin), .shiftout(shiftout_a), .busy(busy_a),
        .m_valid(m_valid_a), .m_data(m_data_a)
    );

    shiftreg_engine #(.WIDTH(8), .LANES(1), .DIRECTION(1)) dut_b (
        .clk(clk), .aclr_n(aclr_n), .abort(abort), .en(en),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data[7:0]), .len(len),
        .shiftin(shiftin[0:0]), .shiftout(shiftout_b), .busy(busy_b),
        .m_valid(m_valid_b), .m_data(m_data_b)
    );

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: unit 0/1 = lanes 0/1 of dut_a (right), unit 2 = dut_b (left).
    // Each unit is a bit queue: element 0 is the bit on shiftout, new bits
    // join at the far end. Received bits are recorded in arrival order.
    bit          mq  [3][8];
    bit          mrx [3][8];
    int          m_n   = 0;
    int          m_got = 0;
    bit          m_busy = 1'b0;
    bit          m_mv   = 1'b0;
    logic [15:0] m_md_a = 16'h0000;
    logic [7:0]  m_md_b = 8'h00;

    always @(posedge clk or negedge aclr_n) begin : model
        logic [7:0] w;
        logic       si;
        logic [7:0] md [3];
        if (!aclr_n) begin
            m_busy = 1'b0; m_mv = 1'b0; m_got = 0; m_n = 0;
            m_md_a = 16'h0000; m_md_b = 8'h00;
            for (int u = 0; u < 3; u++) for (int i = 0; i < 8; i++) mq[u][i] = 1'b0;
        end else begin
            m_mv = 1'b0;
            if (abort) begin
                m_busy = 1'b0; m_got = 0;
                for (int u = 0; u < 3; u++) for (int i = 0; i < 8; i++) mq[u][i] = 1'b0;
            end else if (!m_busy) begin
                if (s_valid) begin
                    for (int u = 0; u < 3; u++) begin
                        w = (u == 1) ? s_data[15:8] : s_data[7:0];
                        for (int i = 0; i < 8; i++) mq[u][i] = (u == 2) ? w[7-i] : w[i];
                    end
                    m_n    = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
                    m_got  = 0;
                    m_busy = 1'b1;
                end
            end else if (en) begin
                for (int u = 0; u < 3; u++) begin
                    si = (u == 1) ? shiftin[1] : shiftin[0];
                    for (int i = 0; i < 7; i++) mq[u][i] = mq[u][i+1];
                    mq[u][7] = si;
                    mrx[u][m_got] = si;
                end
                m_got++;
                if (m_got == m_n) begin
                    m_busy = 1'b0;
                    m_mv   = 1'b1;
                    for (int u = 0; u < 3; u++) begin
                        md[u] = 8'h00;
                        for (int j = 0; j < m_n; j++)
                            md[u][j] = (u == 2) ? mrx[u][m_n-1-j] : mrx[u][j];
                    end
                    m_md_a = {md[1], md[0]};
                    m_md_b = md[2];
                end
            end
        end
    end

    // Every cycle, compare both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_ready",    16'(s_ready_a),  16'(!m_busy));
            check("a_busy",     16'(busy_a),     16'(m_busy));
            check("a_mvalid",   16'(m_valid_a),  16'(m_mv));
            check("a_mdata",    m_data_a,        m_md_a);
            check("a_shiftout", 16'(shiftout_a), 16'({mq[1][0], mq[0][0]}));
            check("b_ready",    16'(s_ready_b),  16'(!m_busy));
            check("b_busy",     16'(busy_b),     16'(m_busy));
            check("b_mvalid",   16'(m_valid_b),  16'(m_mv));
            check("b_mdata",    16'(m_data_b),   16'(m_md_b));
            check("b_shiftout", 16'(shiftout_b), 16'(mq[2][0]));
        end
    end

    int gp [8] = '{0, 2, 0, 1, 3, 0, 1, 0};

    // Starts at a falling edge: load, then n strobed shifts (optional gaps).
    // Bit i of v0/v1 is the serial input for shift i. Returns at the falling
    // edge after the last shift, where the completion pulse is visible.
    task automatic run_frame(input logic [15:0] d, input logic [3:0] l,
                             input logic [7:0] v0, input logic [7:0] v1,
                             input int n, input bit gaps,
                             output logic [7:0] so_a0, output logic [7:0] so_a1,
                             output logic [7:0] so_b);
        so_a0 = 8'h00; so_a1 = 8'h00; so_b = 8'h00;
        s_data = d; len = l; s_valid = 1'b1; en = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            so_a0[i] = shiftout_a[0];
            so_a1[i] = shiftout_a[1];
            so_b[i]  = shiftout_b[0];
            if (gaps) begin
                for (int g = 0; g < gp[i]; g++) begin
                    en = 1'b0;
                    @(negedge clk);
                    check("gap_busy", 16'({busy_a, busy_b}), 16'h0003);
                end
            end
            en = 1'b1;
            shiftin = {v1[i], v0[i]};
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    logic [7:0] sa0, sa1, sb;

    initial begin
        #1 aclr_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", {m_data_a[7:0], 4'h0, s_ready_a, busy_a, shiftout_a}, 16'h0008);
        check("rst_b", {m_data_b, 5'h0, s_ready_b, busy_b, m_valid_b}, 16'h0004);
        aclr_n = 1'b1;
        @(negedge clk);

        // Full frame, MSB-first on the left instance.
        run_frame(16'h00A5, 4'd0, 8'h3C, 8'h00, 8, 1'b0, sa0, sa1, sb);
        check("t1_so_b",  16'(sb), 16'h00A5);
        check("t1_so_a0", 16'(sa0), 16'h00A5);
        check("t1_mv",    16'({m_valid_a, m_valid_b, s_ready_a, s_ready_b}), 16'h000F);
        check("t1_md_b",  16'(m_data_b), 16'h003C);
        check("t1_md_a",  m_data_a, 16'h003C);

        // Back-to-back short frame, loaded during the completion cycle.
        run_frame(16'h000B, 4'd4, 8'h09, 8'h00, 4, 1'b0, sa0, sa1, sb);
        check("t2_so_a0", 16'(sa0), 16'h000B);
        check("t2_so_b",  16'(sb), 16'h0000);
        check("t2_md_a",  m_data_a, 16'h0009);
        check("t2_md_b",  16'(m_data_b), 16'h0009);

        // Two lanes with constant serial inputs.
        run_frame(16'h55AA, 4'd8, 8'h00, 8'hFF, 8, 1'b0, sa0, sa1, sb);
        check("t3_so_a0", 16'(sa0), 16'h00AA);
        check("t3_so_a1", 16'(sa1), 16'h0055);
        check("t3_md_a",  m_data_a, 16'hFF00);
        check("t3_md_b",  16'(m_data_b), 16'h0000);
        @(negedge clk);

        // Same as the first frame but with strobe gaps.
        run_frame(16'h00A5, 4'd0, 8'h3C, 8'h00, 8, 1'b1, sa0, sa1, sb);
        check("t4_so_b", 16'(sb), 16'h00A5);
        check("t4_md_b", 16'(m_data_b), 16'h003C);
        check("t4_mv",   16'({m_valid_a, m_valid_b}), 16'h0003);
        @(negedge clk);
        check("t4_pulse", 16'({m_valid_a, m_valid_b}), 16'h0000);

        // Abort after three shifts, with a competing load.
        s_data = 16'h1234; len = 4'd8; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; en = 1'b1; shiftin = 2'b11;
        repeat (3) @(negedge clk);
        abort = 1'b1; s_valid = 1'b1; s_data = 16'h7777;
        @(negedge clk);
        abort = 1'b0; s_valid = 1'b0; en = 1'b0;
        check("t5_idle", 16'({s_ready_a, busy_a, m_valid_a, s_ready_b, busy_b, m_valid_b}), 16'h0024);
        check("t5_md",   m_data_a, 16'h003C);
        check("t5_so",   16'({shiftout_a, shiftout_b}), 16'h0000);
        run_frame(16'h00C3, 4'd8, 8'h0F, 8'hF0, 8, 1'b0, sa0, sa1, sb);
        check("t5_md_a", m_data_a, 16'hF00F);
        check("t5_md_b", 16'(m_data_b), 16'h00F0);
        @(negedge clk);

        // Asynchronous reset between edges in the middle of a frame.
        s_data = 16'h5A5A; len = 4'd8; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; en = 1'b1; shiftin = 2'b01;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 aclr_n = 1'b0;
        #1;
        check("t6_rst_a", {m_data_a[11:0], s_ready_a, busy_a, m_valid_a, shiftout_a[0]}, 16'h0008);
        check("t6_rst_md", m_data_a, 16'h0000);
        check("t6_rst_b", {m_data_b, 4'h0, s_ready_b, busy_b, m_valid_b, shiftout_b}, 16'h0008);
        en = 1'b0;
        @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);

        // Oversized length clamps to a full word.
        run_frame(16'h0081, 4'd11, 8'h01, 8'h80, 8, 1'b0, sa0, sa1, sb);
        check("t6_mv",   16'({m_valid_a, m_valid_b}), 16'h0003);
        check("t6_md_a", m_data_a, 16'h8001);
        check("t6_md_b", 16'(m_data_b), 16'h0080);
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shiftreg_engine.md
Name: shiftreg_engine

Overview:
Parametrised multi-lane serial shift engine; successor to the single-lane Shiftreg. Accepts one parallel word per lane over a valid/ready handshake and shifts it out over a programmable frame length of 1..WIDTH bits, gated by an external bit strobe. Simultaneously captures the incoming serial bits and returns them as an aligned parallel word with a one-cycle completion pulse. Sits between register/control logic and serial front-ends (SPI-style links, daisy-chained shift chains).

Parameters:
WIDTH, 8, bits per lane shift register; WIDTH >= 2
LANES, 1, number of parallel lanes sharing one control path; LANES >= 1
DIRECTION, 0, 0 = shift right (LSB out first, shiftin enters bit WIDTH-1); 1 = shift left (MSB out first, shiftin enters bit 0)
CW, $clog2(WIDTH+1), width of len and bit counter (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
aclr_n  input  1  asynchronous active-low reset
abort  input  1  synchronous frame abort, active-high
en  input  1  bit strobe; one shift per clk cycle with en=1 while busy
s_valid  input  1  load request
s_ready  output  1  engine idle and able to accept a load
s_data  input  LANES*WIDTH  parallel load data; lane k = s_data[k*WIDTH +: WIDTH]
len  input  CW  frame length in bits, sampled at load; 0 means WIDTH; values > WIDTH clamp to WIDTH
shiftin  input  LANES  serial input, bit k for lane k
shiftout  output  LANES  serial output, bit k for lane k
busy  output  1  frame in progress
m_valid  output  1  one-cycle pulse: frame complete, m_data updated
m_data  output  LANES*WIDTH  received word per lane, low-justified

Behaviour:
- Reset (aclr_n=0, asynchronous): state IDLE, shift regs 0, bit counter 0, m_data 0, m_valid 0. Consequently s_ready=1, busy=0, shiftout=0.
- States: IDLE and SHIFT. s_ready = (state==IDLE); busy = (state==SHIFT). Both are decoded combinationally from the state register.
- IDLE:
  - s_valid=1 at an edge loads every lane register from s_data and loads the counter with the effective len. Next state is SHIFT.
  - en is ignored in IDLE; registers hold.
- SHIFT:
  - On each edge with en=1, every lane shifts one position per DIRECTION, inserting shiftin[k], and the counter decrements.
  - On the edge where en=1 and counter==1: next state IDLE, m_valid<=1, and m_data<=aligned result of the post-shift register.
  - en=0 holds all state; strobe gaps of any length are legal.
  - s_valid is ignored while in SHIFT (s_ready=0).
- shiftout[k] is always the current register bit: bit 0 when DIRECTION=0, bit WIDTH-1 when DIRECTION=1. The first bit is therefore valid the cycle after load, before the first en.
- Alignment of m_data (n = effective len): the received bits occupy bits [n-1:0]; bits [WIDTH-1:n] are 0.
  - DIRECTION=0: lane m_data = reg >> (WIDTH-n). The first received bit lands at bit 0.
  - DIRECTION=1: lane m_data = reg & mask(n). The last received bit lands at bit 0.
- m_data holds its value until the next completed frame. Abort and load do not change it.
- m_valid is high for exactly one cycle. Because s_ready is already 1 in that cycle, a back-to-back load is accepted in the same cycle m_valid is high.
- abort=1 at an edge, in any state: state IDLE, shift regs and counter cleared, no m_valid. abort has priority over s_valid and en in the same cycle.
- Reset asserted mid-frame: immediate return to reset values, no m_valid. The frame is lost.
- Frame timing: s_valid high at edge 0; SHIFT occupies edges 1..n with en held high; m_valid is high in the cycle following edge n.

Test Plan:
- WIDTH=8, LANES=1, DIRECTION=1; load 0xA5, len=0, en held high, shiftin driven with 0x3C MSB first -> shiftout sequence 1,0,1,0,0,1,0,1; m_valid pulses once after the 8th shift; m_data=0x3C; s_ready returns to 1 in the same cycle.
- DIRECTION=0, len=4; load 0x0B, shiftin bits 1,0,0,1 -> shiftout 1,1,0,1; m_data=0x09; upper nibble 0.
- LANES=2, WIDTH=8, DIRECTION=0; s_data=0x55AA, len=8, shiftin={lane1=1, lane0=0} constant -> m_data=0xFF00. Lane 0 shiftout sequence is the bits of 0xAA LSB first; lane 1 is the bits of 0x55 LSB first.
- en toggled 1,0,0,1,... with random gaps over an 8-bit frame -> exactly 8 shifts occur; busy stays high throughout the gaps; result identical to the gap-free run.
- abort after 3 shifts of 8, with s_valid=1 in the same cycle -> back in IDLE, load ignored, no m_valid, m_data unchanged from the previous frame. A fresh load on the next cycle completes normally.
- Assert aclr_n=0 mid-frame, asynchronously between edges -> shiftout, busy, m_valid and m_data go to 0 immediately and s_ready=1. After release, a len=WIDTH+3 load is clamped and performs exactly WIDTH shifts.
